serial_7seg_receiver: RTL and testbench

SERIAL_7SEG_RECEIVER -- requirements
Module: serial_7seg_receiver

---
 rtl/serial_7seg_receiver.sv | 145 ++++++++++++++
 tb/tb_serial_7seg_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_7seg_receiver.sv
// Serial 6-digit 7-segment frame receiver: synchronizes the serial lines, shifts in 48-bit frames,
// decodes segment patterns to BCD digits. Define SERIAL_RX_RAW_EN to expose the accepted raw frame.
module serial_7seg_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 48
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_serial_data,
  input  logic       i_serial_clk,
  input  logic       i_serial_latch,
  output logic [3:0] o_hours_msb,
  output logic [3:0] o_hours_lsb,
  output logic [3:0] o_minutes_msb,
  output logic [3:0] o_minutes_lsb,
  output logic [3:0] o_seconds_msb,
  output logic [3:0] o_seconds_lsb,
  output logic       o_dp_hours1,
  output logic       o_dp_hours2,
  output logic       o_dp_minutes1,
  output logic       o_dp_minutes2,
  output logic       o_dp_seconds1,
  output logic       o_dp_seconds2,
  output logic       o_frame_stb,
  output logic       o_frame_err,
  output logic       o_decode_err
`ifdef SERIAL_RX_RAW_EN
  ,
  output logic [FRAME_BITS-1:0] o_raw_frame
`endif
);

  localparam int         DIGITS      = 6;
  localparam logic [5:0] FRAME_COUNT = 6'(FRAME_BITS);
  localparam logic [5:0] COUNT_MAX   = 6'd63;

  logic [SYNC_STAGES-1:0] data_sync, sclk_sync, latch_sync;
  logic                   sclk_prev, latch_prev;
  logic                   data_s, sclk_rise, latch_rise;

  logic [FRAME_BITS-1:0]  shift_reg, shift_next;
  logic [5:0]             bit_count, count_next;
  logic                   frame_ok, any_illegal;
  logic [4:0]             dec [DIGITS];
  logic [DIGITS-1:0]      dp_next;

  logic [3:0]             digit_q [DIGITS];
  logic [DIGITS-1:0]      dp_q;

  // Returns {illegal, digit}; blank decodes to 4'hF and is legal.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = {1'b0, 4'h0};
      7'h06:   r = {1'b0, 4'h1};
      7'h5B:   r = {1'b0, 4'h2};
      7'h4F:   r = {1'b0, 4'h3};
      7'h66:   r = {1'b0, 4'h4};
      7'h6D:   r = {1'b0, 4'h5};
      7'h7D:   r = {1'b0, 4'h6};
      7'h07:   r = {1'b0, 4'h7};
      7'h7F:   r = {1'b0, 4'h8};
      7'h6F:   r = {1'b0, 4'h9};
      7'h00:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'hE};
    endcase
    return r;
  endfunction

  assign data_s     = data_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_prev;

  // A shift coinciding with the latch is folded in before the latch looks at the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shift_next  = shift_reg;
    count_next  = bit_count;
    any_illegal = 1'b0;
    if (sclk_rise) begin
      shift_next = {shift_reg[FRAME_BITS-2:0], data_s};
      if (bit_count != COUNT_MAX) count_next = bit_count + 6'd1;
    end
    for (int k = 0; k < DIGITS; k++) begin
      dp_next[k]  = shift_next[FRAME_BITS-1-8*k];
      dec[k]      = decode_seg(shift_next[FRAME_BITS-2-8*k -: 7]);
      any_illegal = any_illegal | dec[k][4];
    end
    frame_ok = latch_rise && (count_next == FRAME_COUNT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      data_sync    <= '0;
      sclk_sync    <= '0;
      latch_sync   <= '0;
      sclk_prev    <= 1'b0;
      latch_prev   <= 1'b0;
      // NOTE: the shift register is cleared too, so a reset mid-frame leaves no stale bits behind.
      shift_reg    <= '0;
      bit_count    <= '0;
      o_frame_stb  <= 1'b0;
      o_frame_err  <= 1'b0;
      o_decode_err <= 1'b0;
      dp_q         <= '0;
      for (int k = 0; k < DIGITS; k++) digit_q[k] <= 4'h0;
`ifdef SERIAL_RX_RAW_EN
      o_raw_frame  <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      data_sync    <= {data_sync[SYNC_STAGES-2:0], i_serial_data};
      sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], i_serial_clk};
      latch_sync   <= {latch_sync[SYNC_STAGES-2:0], i_serial_latch};
      sclk_prev    <= sclk_sync[SYNC_STAGES-1];
      latch_prev   <= latch_sync[SYNC_STAGES-1];
      shift_reg    <= shift_next;
      bit_count    <= latch_rise ? 6'd0 : count_next;
      o_frame_stb  <= frame_ok;
      o_frame_err  <= latch_rise && !frame_ok;
      o_decode_err <= frame_ok && any_illegal;
      if (frame_ok) begin
        dp_q <= dp_next;
        for (int k = 0; k < DIGITS; k++) digit_q[k] <= dec[k][3:0];
`ifdef SERIAL_RX_RAW_EN
        o_raw_frame <= shift_next;
`endif
      end
    end
  end

  assign o_hours_msb   = digit_q[0];
  assign o_hours_lsb   = digit_q[1];
  assign o_minutes_msb = digit_q[2];
  assign o_minutes_lsb = digit_q[3];
  assign o_seconds_msb = digit_q[4];
  assign o_seconds_lsb = digit_q[5];
  assign o_dp_hours1   = dp_q[0];
  assign o_dp_hours2   = dp_q[1];
  assign o_dp_minutes1 = dp_q[2];
  assign o_dp_minutes2 = dp_q[3];
  assign o_dp_seconds1 = dp_q[4];
  assign o_dp_seconds2 = dp_q[5];

endmodule

// File: tb/tb_serial_7seg_receiver.sv
// Randomized self-checking bench for serial_7seg_receiver: a bit-queue reference model predicts
// each latch outcome; a per-cycle monitor compares pulses and held outputs against it.
module tb_serial_7seg_receiver;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic sd = 1'b0, sc = 1'b0, sl = 1'b0;
  logic [3:0] hm, hl, mm, ml, sm, sls;
  logic dph1, dph2, dpm1, dpm2, dps1, dps2;
  logic stb, ferr, derr;
`ifdef SERIAL_RX_RAW_EN
  logic [47:0] raw;
`endif

  serial_7seg_receiver dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_serial_data(sd), .i_serial_clk(sc), .i_serial_latch(sl),
    .o_hours_msb(hm), .o_hours_lsb(hl), .o_minutes_msb(mm), .o_minutes_lsb(ml),
    .o_seconds_msb(sm), .o_seconds_lsb(sls),
    .o_dp_hours1(dph1), .o_dp_hours2(dph2), .o_dp_minutes1(dpm1), .o_dp_minutes2(dpm2),
    .o_dp_seconds1(dps1), .o_dp_seconds2(dps2),
    .o_frame_stb(stb), .o_frame_err(ferr), .o_decode_err(derr)
`ifdef SERIAL_RX_RAW_EN
    , .o_raw_frame(raw)
`endif
  );

  always #10 i_clk = ~i_clk;  // 50 MHz

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every bit received since the last latch/reset, in arrival order.
  bit          q[$];
  logic [6:0]  seg_of [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [23:0] exp_dig = '0;
  logic [5:0]  exp_dp = '0;
  logic [47:0] exp_raw = '0;
  int          pend = 0;           // 0 none, 1 frame strobe expected, 2 frame error expected
  logic [23:0] pend_dig;
  logic [5:0]  pend_dp;
  logic        pend_dec;
  logic [47:0] pend_raw;
  int          stb_seen = 0, err_seen = 0;
  logic        last_dec = 1'b0;

  function automatic logic [4:0] model_decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (seg_of[i] == s) return {1'b0, 4'(i)};
    if (s == 7'h00) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  // Builds a frame from digit codes (F = blank) and dps ordered {h1,h2,m1,m2,s1,s2}.
  function automatic logic [47:0] make_frame(input logic [23:0] digs, input logic [5:0] dps);
    logic [47:0] w;
    logic [3:0]  d;
    for (int k = 0; k < 6; k++) begin
      d = digs[23-4*k -: 4];
      w[47-8*k -: 8] = {dps[5-k], (d == 4'hF) ? 7'h00 : seg_of[d]};
    end
    return w;
  endfunction

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      exp_dig = '0; exp_dp = '0; exp_raw = '0; pend = 0;
    end else begin
      check("stb_err_exclusive", 64'(stb & ferr), 64'd0);
      if (stb) begin
        check("stb_expected", 64'(pend), 64'd1);
        check("decode_err", 64'(derr), 64'(pend_dec));
        exp_dig = pend_dig; exp_dp = pend_dp; exp_raw = pend_raw;
        last_dec = derr; stb_seen++; pend = 0;
      end else begin
        check("decode_err_alone", 64'(derr), 64'd0);
      end
      if (ferr) begin
        check("err_expected", 64'(pend), 64'd2);
        err_seen++; pend = 0;
      end
      check("digits", 64'({hm, hl, mm, ml, sm, sls}), 64'(exp_dig));
      check("dps", 64'({dph1, dph2, dpm1, dpm2, dps1, dps2}), 64'(exp_dp));
`ifdef SERIAL_RX_RAW_EN
      check("raw_frame", 64'(raw), 64'(exp_raw));
`endif
    end
  end

  task automatic send_bit(input bit b, input int half);
    sd = b;
    repeat (half) @(posedge i_clk);
    #3 sc = 1'b1;
    q.push_back(b);
    repeat (half) @(posedge i_clk);
    #3 sc = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] w, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], half);
  endtask

  task automatic do_latch();
    logic [6:0] s;
    logic [4:0] d;
    repeat (3) @(posedge i_clk);
    #3;
    if (q.size() == 48) begin
      pend_dec = 1'b0;
      for (int k = 0; k < 6; k++) begin
        pend_dp[5-k] = q[8*k];
        for (int j = 0; j < 7; j++) s[6-j] = q[8*k+1+j];
        d = model_decode(s);
        pend_dig[23-4*k -: 4] = d[3:0];
        pend_dec = pend_dec | d[4];
      end
      for (int i = 0; i < 48; i++) pend_raw[47-i] = q[i];
      pend = 1;
    end else begin
      pend = 2;
    end
    q.delete();
    sl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pend == 0) break;
      @(posedge i_clk);
    end
    if (pend != 0) begin
      check("latch_response_timeout", 64'(pend), 64'd0);
      pend = 0;
    end
    #3 sl = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #3 i_reset_n = 1'b0;
    q.delete();
    repeat (3) @(posedge i_clk);
    #3 i_reset_n = 1'b1;
  endtask

  initial begin
    logic [47:0]  w;
    logic [127:0] rw;
    int s0, e0, n, half;
    logic [23:0] digs;
    logic [5:0]  dps;

    do_reset();
    @(negedge i_clk);
    check("reset_digits", 64'({hm, hl, mm, ml, sm, sls}), 64'd0);
    check("reset_dps", 64'({dph1, dph2, dpm1, dpm2, dps1, dps2}), 64'd0);
    check("reset_pulses", 64'({stb, ferr, derr}), 64'd0);

    // 12:34:56 at 1 MHz (25 clocks per phase)
    w = make_frame(24'h123456, 6'b0);
    check("model_frame_123456", 64'(w), 64'h065B4F666D7D);
    s0 = stb_seen; e0 = err_seen;
    send_bits(128'(w), 48, 25);
    do_latch();
    check("f1_digits", 64'({hm, hl, mm, ml, sm, sls}), 64'h123456);
    check("f1_dps", 64'({dph1, dph2, dpm1, dpm2, dps1, dps2}), 64'd0);
    check("f1_stb_count", 64'(stb_seen - s0), 64'd1);
    check("f1_err_count", 64'(err_seen - e0), 64'd0);
    check("f1_decode_err", 64'(last_dec), 64'd0);
`ifdef SERIAL_RX_RAW_EN
    check("f1_raw", 64'(raw), 64'h065B4F666D7D);
`endif

    // 47 bits then latch: frame error, outputs held
    s0 = stb_seen; e0 = err_seen;
    send_bits(128'(make_frame(24'h987654, 6'h2A)), 47, 5);
    do_latch();
    check("short_err_count", 64'(err_seen - e0), 64'd1);
    check("short_stb_count", 64'(stb_seen - s0), 64'd0);
    check("short_held", 64'({hm, hl, mm, ml, sm, sls}), 64'h123456);

    // all-zero frame: all blank, legal
    s0 = stb_seen;
    send_bits(128'd0, 48, 4);
    do_latch();
    check("blank_digits", 64'({hm, hl, mm, ml, sm, sls}), 64'hFFFFFF);
    check("blank_stb_count", 64'(stb_seen - s0), 64'd1);
    check("blank_decode_err", 64'(last_dec), 64'd0);

    // illegal seconds_lsb pattern 0x7E with dp_minutes2 set
    w = make_frame(24'h010203, 6'b000100);
    w[6:0] = 7'h7E;
    s0 = stb_seen;
    send_bits(128'(w), 48, 4);
    do_latch();
    check("bad_sec_lsb", 64'(sls), 64'hE);
    check("bad_dp_m2", 64'(dpm2), 64'd1);
    check("bad_digits", 64'({hm, hl, mm, ml, sm, sls}), 64'h01020E);
    check("bad_decode_err", 64'(last_dec), 64'd1);
    check("bad_stb_count", 64'(stb_seen - s0), 64'd1);

    // reset after 20 bits, then 09:59:59
    send_bits(128'(make_frame(24'h777777, 6'h3F)), 20, 4);
    repeat (6) @(posedge i_clk);
    do_reset();
    s0 = stb_seen; e0 = err_seen;
    send_bits(128'(make_frame(24'h095959, 6'b0)), 48, 4);
    do_latch();
    check("post_reset_digits", 64'({hm, hl, mm, ml, sm, sls}), 64'h095959);
    check("post_reset_err_count", 64'(err_seen - e0), 64'd0);
    check("post_reset_stb_count", 64'(stb_seen - s0), 64'd1);

    // length boundaries: 49, 0, and 112 (saturating count must not wrap back to 48)
    e0 = err_seen;
    send_bits(128'(make_frame(24'h111111, 6'h0)), 49, 3);
    do_latch();
    do_latch();
    rw = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rw, 112, 3);
    do_latch();
    check("boundary_err_count", 64'(err_seen - e0), 64'd3);
    check("boundary_held", 64'({hm, hl, mm, ml, sm, sls}), 64'h095959);

    // randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      half = $urandom_range(3, 8);
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 70) : 48;
      for (int k = 0; k < 6; k++) begin
        logic [4:0] pick;
        pick = 5'($urandom_range(0, 13));
        digs[23-4*k -: 4] = (pick < 10) ? pick[3:0] : 4'hF;
      end
      dps = 6'($urandom);
      w = make_frame(digs, dps);
      if ($urandom_range(0, 3) == 0) w[8*$urandom_range(0, 5) +: 7] = 7'($urandom);
      rw = {$urandom, $urandom, $urandom, $urandom};
      if (n == 48) rw = 128'(w);
      send_bits(rw, n, half);
      do_latch();
    end

    check("random_activity", 64'(stb_seen > 10), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
